// File: rtl/vga_frame_engine.sv
// rtl/vga_frame_engine.sv - VGA timing, windowed framebuffer fetch and pixel output
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN.
module vga_frame_engine #(
  parameter int          H_ACTIVE  = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_ACTIVE  = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33,
  parameter int          SYNC_POL  = 0,
  parameter int          IMG_W     = 256,
  parameter int          IMG_H     = 256,
  parameter int          SCALE     = 1,
  parameter int          ADDR_W    = 18,
  parameter int          DATA_W    = 32,
  parameter int          MEM_LAT   = 1,
  parameter int          PIX_FMT   = 0,
  parameter int          IMG0_BASE = 0,
  parameter int          IMG1_BASE = IMG_W * IMG_H,
  parameter logic [23:0] BORDER    = 24'h000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              image_sel,
  input  logic              enable,
`ifdef VGA_TEST_PATTERN_EN
  input  logic              test_mode,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_data,
  output logic              frame_start,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_N,
  output logic              VGA_SYNC_N
);
  localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int   HW      = $clog2(H_TOTAL);
  localparam int   VW      = $clog2(V_TOTAL);
  localparam int   LAT     = MEM_LAT;
  localparam logic POL     = (SYNC_POL != 0);

  logic [HW-1:0]       h_q, h_d;
  logic [VW-1:0]       v_q, v_d;
  logic [3:0]          sub_q, sub_d, rsub_q, rsub_d;
  logic [ADDR_W-1:0]   col_q, col_d, row_q, row_d, hold_q;
  logic                img_q, img_d, line_en_q, fs_q;
  logic                h_wrap, v_wrap, f_wrap;
  logic                hs_raw, vs_raw, vis_raw, inwin_raw, line_en, rd_en;
  logic [ADDR_W-1:0]   base;
  logic [LAT:0][2:0]   spipe_q;
  logic [LAT-1:0][1:0] cpipe_q;
  logic [23:0]         pix, rgb_d, rgb_q;
`ifdef VGA_TEST_PATTERN_EN
  logic                tm_q;
  logic [2:0]          bar_q;
  logic [HW-1:0]       bar_px_q;
  logic [LAT-1:0][3:0] tpipe_q;
`endif

  always_comb begin
    h_wrap    = (32'(h_q) == H_TOTAL - 1);
    v_wrap    = (32'(v_q) == V_TOTAL - 1);
    f_wrap    = h_wrap && v_wrap;
    hs_raw    = (32'(h_q) >= H_ACTIVE + H_FP) && (32'(h_q) < H_ACTIVE + H_FP + H_SYNC);
    vs_raw    = (32'(v_q) >= V_ACTIVE + V_FP) && (32'(v_q) < V_ACTIVE + V_FP + V_SYNC);
    vis_raw   = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
    inwin_raw = vis_raw && (32'(h_q) < IMG_W * SCALE) && (32'(v_q) < IMG_H * SCALE);
    // enable is taken live at h=0 so the first line after reset already honours it
    line_en   = (h_q == '0) ? enable : line_en_q;
    rd_en     = inwin_raw && line_en && !rst;
`ifdef VGA_TEST_PATTERN_EN
    rd_en     = rd_en && !tm_q;
`endif
    base      = img_q ? ADDR_W'(IMG1_BASE) : ADDR_W'(IMG0_BASE);
    mem_addr  = rd_en ? (base + row_q + col_q) : hold_q;
    mem_rd_en = rd_en;
  end

  always_comb begin
    h_d = h_wrap ? '0 : h_q + 1'b1;
    v_d = v_q;
    if (h_wrap) v_d = v_wrap ? '0 : v_q + 1'b1;
    sub_d = sub_q + 1'b1;
    col_d = col_q;
    if (h_wrap) begin
      sub_d = '0;
      col_d = '0;
    end else if (32'(sub_q) == SCALE - 1) begin
      sub_d = '0;
      col_d = col_q + 1'b1;
    end
    rsub_d = rsub_q;
    row_d  = row_q;
    if (f_wrap) begin
      rsub_d = '0;
      row_d  = '0;
    end else if (h_wrap) begin
      if (32'(rsub_q) == SCALE - 1) begin
        rsub_d = '0;
        row_d  = row_q + ADDR_W'(IMG_W);
      end else begin
        rsub_d = rsub_q + 1'b1;
      end
    end
    img_d = f_wrap ? image_sel : img_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q       <= '0;
      v_q       <= '0;
      sub_q     <= '0;
      col_q     <= '0;
      rsub_q    <= '0;
      row_q     <= '0;
      hold_q    <= '0;
      img_q     <= 1'b0;
      line_en_q <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      sub_q     <= sub_d;
      col_q     <= col_d;
      rsub_q    <= rsub_d;
      row_q     <= row_d;
      hold_q    <= mem_addr;
      img_q     <= img_d;
      line_en_q <= line_en;
      fs_q      <= f_wrap;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tm_q     <= 1'b0;
      bar_q    <= '0;
      bar_px_q <= '0;
    end else begin
      if (f_wrap) tm_q <= test_mode;
      if (h_wrap) begin
        bar_q    <= '0;
        bar_px_q <= '0;
      end else if (32'(bar_px_q) == H_ACTIVE / 8 - 1) begin
        bar_q    <= bar_q + 1'b1;
        bar_px_q <= '0;
      end else begin
        bar_px_q <= bar_px_q + 1'b1;
      end
    end
  end
`endif

  // Sync/blank travel LAT+1 stages; colour controls need only LAT to meet mem_data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spipe_q <= '0;
      cpipe_q <= '0;
      rgb_q   <= '0;
`ifdef VGA_TEST_PATTERN_EN
      tpipe_q <= '0;
`endif
    end else begin
      spipe_q[0] <= {hs_raw, vs_raw, vis_raw};
      for (int i = 1; i <= LAT; i++) spipe_q[i] <= spipe_q[i-1];
      cpipe_q[0] <= {vis_raw, inwin_raw && line_en};
      for (int i = 1; i < LAT; i++) cpipe_q[i] <= cpipe_q[i-1];
`ifdef VGA_TEST_PATTERN_EN
      tpipe_q[0] <= {tm_q, bar_q};
      for (int i = 1; i < LAT; i++) tpipe_q[i] <= tpipe_q[i-1];
`endif
      rgb_q <= rgb_d;
    end
  end

  always_comb begin
    pix   = (PIX_FMT != 0) ? mem_data[23:0] : {3{mem_data[7:0]}};
    rgb_d = 24'h000000;
    if (cpipe_q[LAT-1][1]) rgb_d = cpipe_q[LAT-1][0] ? pix : BORDER;
`ifdef VGA_TEST_PATTERN_EN
    // bar index b: R = ~b[1], G = ~b[2], B = ~b[0] gives white..black order
    if (cpipe_q[LAT-1][1] && tpipe_q[LAT-1][3])
      rgb_d = {{8{~tpipe_q[LAT-1][1]}}, {8{~tpipe_q[LAT-1][2]}}, {8{~tpipe_q[LAT-1][0]}}};
`endif
  end

  assign frame_start = fs_q;
  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign VGA_HS      = spipe_q[LAT][2] ? POL : ~POL;
  assign VGA_VS      = spipe_q[LAT][1] ? POL : ~POL;
  assign VGA_BLANK_N = spipe_q[LAT][0];
  assign VGA_SYNC_N  = 1'b0;
endmodule

// File: tb/tb_vga_frame_engine.sv
// tb/tb_vga_frame_engine.sv - directed checks of timing, fetch, latency, image select, enable and reset
module tb_vga_frame_engine;
  localparam logic [23:0] BRD = 24'h123456;

  logic        clk = 1'b0, rst = 1'b1, image_sel = 1'b0, enable = 1'b1;
  logic [7:0]  mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_data;
  logic        frame_start, hs, vs, blank_n, sync_n;
  logic [7:0]  r, g, b;
  int          tests = 0, fails = 0;
  int          cyc;
  logic        rec_en = 1'b1;
  logic        rec_rd [0:1023];
  logic [7:0]  rec_addr [0:1023];
  logic [23:0] rec_rgb [0:1023];
  logic        rec_hs [0:1023];
  logic        rec_vs [0:1023];
  logic        rec_bl [0:1023];
  logic        rec_fs [0:1023];
  logic [7:0]  md1 = 8'hEE, md2 = 8'hEE, md3 = 8'hEE;

  always #5 clk = ~clk;

  vga_frame_engine #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(0), .IMG_W(4), .IMG_H(4), .SCALE(2),
    .ADDR_W(8), .DATA_W(32), .MEM_LAT(3), .PIX_FMT(0),
    .IMG0_BASE(0), .IMG1_BASE(16), .BORDER(BRD)
  ) dut (
    .clk(clk), .rst(rst), .image_sel(image_sel), .enable(enable),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(1'b0),
`endif
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_data(mem_data),
    .frame_start(frame_start), .VGA_R(r), .VGA_G(g), .VGA_B(b),
    .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(blank_n), .VGA_SYNC_N(sync_n)
  );

  // Cycle index equals h + 24*v within a frame (24x16 timing, 384 cycles/frame)
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  // 3-cycle memory returning the low address byte; 0xEE when not strobed
  always @(posedge clk) begin
    md1 <= mem_rd_en ? mem_addr : 8'hEE;
    md2 <= md1;
    md3 <= md2;
  end
  assign mem_data = {24'h0, md3};

  always @(negedge clk)
    if (rec_en && !rst && cyc < 1024) begin
      rec_rd[cyc]   <= mem_rd_en;
      rec_addr[cyc] <= mem_addr;
      rec_rgb[cyc]  <= {r, g, b};
      rec_hs[cyc]   <= hs;
      rec_vs[cyc]   <= vs;
      rec_bl[cyc]   <= blank_n;
      rec_fs[cyc]   <= frame_start;
    end

  task automatic goto(input int n);
    int guard = 0;
    while (cyc < n && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (cyc != n) begin
      fails++;
      $display("FAIL goto: cycle %0d expected %0d", cyc, n);
    end
  endtask

  task automatic test_reset(input string tag);
    tests++;
    if ({r, g, b} !== 24'h0) begin fails++; $display("FAIL %s rgb: got %h expected 000000", tag, {r, g, b}); end
    tests++;
    if (hs !== 1'b1 || vs !== 1'b1) begin fails++; $display("FAIL %s sync: got hs=%b vs=%b expected 1 1", tag, hs, vs); end
    tests++;
    if (blank_n !== 1'b0) begin fails++; $display("FAIL %s blank_n: got %b expected 0", tag, blank_n); end
    tests++;
    if (mem_rd_en !== 1'b0 || mem_addr !== 8'h0) begin
      fails++; $display("FAIL %s mem: got rd=%b addr=%h expected 0 00", tag, mem_rd_en, mem_addr);
    end
    tests++;
    if (frame_start !== 1'b0) begin fails++; $display("FAIL %s frame_start: got %b expected 0", tag, frame_start); end
    tests++;
    if (sync_n !== 1'b0) begin fails++; $display("FAIL %s sync_n: got %b expected 0", tag, sync_n); end
  endtask

  task automatic test_image_sel();
    goto(120);
    image_sel = 1'b1;
    goto(390);
    tests++;
    if (rec_rd[144] !== 1'b1 || rec_addr[144] !== 8'd12) begin
      fails++; $display("FAIL imgsel v6: got rd=%b addr=%0d expected 1 12", rec_rd[144], rec_addr[144]);
    end
    tests++;
    if (rec_addr[174] !== 8'd15) begin fails++; $display("FAIL imgsel v7h6: got %0d expected 15", rec_addr[174]); end
    tests++;
    if (rec_rd[384] !== 1'b1 || rec_addr[384] !== 8'd16) begin
      fails++; $display("FAIL imgsel next frame: got rd=%b addr=%0d expected 1 16", rec_rd[384], rec_addr[384]);
    end
    tests++;
    if (rec_addr[387] !== 8'd17) begin fails++; $display("FAIL imgsel h3: got %0d expected 17", rec_addr[387]); end
  endtask

  task automatic test_enable();
    goto(435);
    enable = 1'b0;
    goto(470);
    enable = 1'b1;
    goto(490);
    tests++;
    if (rec_rd[436] !== 1'b1 || rec_addr[436] !== 8'd22) begin
      fails++; $display("FAIL enable same line: got rd=%b addr=%0d expected 1 22", rec_rd[436], rec_addr[436]);
    end
    tests++;
    if (rec_rgb[440] !== 24'h161616) begin fails++; $display("FAIL enable same line pix: got %h expected 161616", rec_rgb[440]); end
    tests++;
    if (rec_rd[456] !== 1'b0 || rec_addr[456] !== 8'd23) begin
      fails++; $display("FAIL enable next line: got rd=%b addr=%0d expected 0 23", rec_rd[456], rec_addr[456]);
    end
    tests++;
    if (rec_rd[458] !== 1'b0) begin fails++; $display("FAIL enable next line h2: got rd=%b expected 0", rec_rd[458]); end
    tests++;
    if (rec_rgb[460] !== BRD) begin fails++; $display("FAIL enable off pix: got %h expected %h", rec_rgb[460], BRD); end
    tests++;
    if (rec_rd[480] !== 1'b1 || rec_addr[480] !== 8'd24) begin
      fails++; $display("FAIL enable resume: got rd=%b addr=%0d expected 1 24", rec_rd[480], rec_addr[480]);
    end
    tests++;
    if (rec_rgb[484] !== 24'h181818) begin fails++; $display("FAIL enable resume pix: got %h expected 181818", rec_rgb[484]); end
  endtask

  task automatic test_timing();
    int   hs_i[4] = '{21, 22, 24, 25};
    logic hs_e[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int   vs_i[4] = '{315, 316, 363, 364};
    logic vs_e[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int   fs_i[4] = '{383, 384, 385, 768};
    logic fs_e[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int   bl_i[6] = '{3, 4, 19, 20, 283, 292};
    logic bl_e[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    goto(770);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (rec_hs[hs_i[i]] !== hs_e[i]) begin fails++; $display("FAIL hsync @%0d: got %b expected %b", hs_i[i], rec_hs[hs_i[i]], hs_e[i]); end
      tests++;
      if (rec_vs[vs_i[i]] !== vs_e[i]) begin fails++; $display("FAIL vsync @%0d: got %b expected %b", vs_i[i], rec_vs[vs_i[i]], vs_e[i]); end
      tests++;
      if (rec_fs[fs_i[i]] !== fs_e[i]) begin fails++; $display("FAIL frame_start @%0d: got %b expected %b", fs_i[i], rec_fs[fs_i[i]], fs_e[i]); end
    end
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (rec_bl[bl_i[i]] !== bl_e[i]) begin fails++; $display("FAIL blank_n @%0d: got %b expected %b", bl_i[i], rec_bl[bl_i[i]], bl_e[i]); end
    end
  endtask

  task automatic test_fetch();
    logic [7:0] a0[8]  = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3};
    int         fi[5]  = '{8, 24, 48, 170, 192};
    logic       fr[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] fa[5]  = '{8'd3, 8'd0, 8'd4, 8'd13, 8'd15};
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (rec_rd[i] !== 1'b1 || rec_addr[i] !== a0[i]) begin
        fails++; $display("FAIL fetch line0 h%0d: got rd=%b addr=%0d expected 1 %0d", i, rec_rd[i], rec_addr[i], a0[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (rec_rd[fi[i]] !== fr[i] || rec_addr[fi[i]] !== fa[i]) begin
        fails++; $display("FAIL fetch @%0d: got rd=%b addr=%0d expected %b %0d", fi[i], rec_rd[fi[i]], rec_addr[fi[i]], fr[i], fa[i]);
      end
    end
  endtask

  task automatic test_latency();
    int          li[6] = '{9, 11, 12, 20, 30, 196};
    logic [23:0] le[6] = '{24'h020202, 24'h030303, BRD, 24'h000000, 24'h010101, BRD};
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (rec_rgb[li[i]] !== le[i]) begin fails++; $display("FAIL pixel @%0d: got %h expected %h", li[i], rec_rgb[li[i]], le[i]); end
    end
    tests++;
    if (rec_bl[9] !== 1'b1) begin fails++; $display("FAIL blank aligned @9: got %b expected 1", rec_bl[9]); end
  endtask

  task automatic test_reset_mid();
    rec_en = 1'b0;
    goto(994);
    tests++;
    if (blank_n !== 1'b1 || {r, g, b} !== BRD) begin
      fails++; $display("FAIL pre-reset: got blank=%b rgb=%h expected 1 %h", blank_n, {r, g, b}, BRD);
    end
    rst = 1'b1;
    #1;
    test_reset("mid reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 8'd0) begin
      fails++; $display("FAIL restart fetch: got rd=%b addr=%0d expected 1 0", mem_rd_en, mem_addr);
    end
    goto(315);
    tests++;
    if (vs !== 1'b1) begin fails++; $display("FAIL restart vs @315: got %b expected 1", vs); end
    goto(316);
    tests++;
    if (vs !== 1'b0) begin fails++; $display("FAIL restart vs @316: got %b expected 0", vs); end
    goto(384);
    tests++;
    if (frame_start !== 1'b1 || mem_addr !== 8'd16) begin
      fails++; $display("FAIL restart frame: got fs=%b addr=%0d expected 1 16", frame_start, mem_addr);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    test_image_sel();
    test_enable();
    test_timing();
    test_fetch();
    test_latency();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vga_frame_engine.md
Name: vga_frame_engine

Overview:
- Parametrised successor to the fixed 640x480 VGA output path.
- Merges the horizontal/vertical counters, sync/blank generation and pixel fetcher into one block, with configurable timing, image window size, integer upscaling, pixel format and configurable framebuffer read latency.
- Adds frame-synchronous double-image selection, line-synchronous enable and a border colour outside the image window.
- Sits between the pixel-clock domain (driven by the existing clock divider) and the image RAM.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (cycles)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
SYNC_POL, 0, sync active level (0 = active-low)
IMG_W, 256, source image width (pixels)
IMG_H, 256, source image height (pixels)
SCALE, 1, integer upscale factor, 1..8
ADDR_W, 18, memory address width
DATA_W, 32, memory data width
MEM_LAT, 1, cycles from mem_rd_en/mem_addr to valid mem_data, 1..4
PIX_FMT, 0, 0 = gray8 in mem_data[7:0] replicated to R/G/B; 1 = RGB888 in mem_data[23:0] (R = [23:16])
IMG0_BASE, 0, word base address of image 0
IMG1_BASE, IMG_W*IMG_H, word base address of image 1
BORDER, 24'h000000, RGB shown in active area outside the image window

Ports:
clk  input  1  pixel clock (25 MHz at defaults)
rst  input  1  asynchronous active-high reset
image_sel  input  1  requested image (0/1)
enable  input  1  display enable
mem_addr  output  ADDR_W  framebuffer word address
mem_rd_en  output  1  read strobe
mem_data  input  DATA_W  read data, valid MEM_LAT cycles after strobe
frame_start  output  1  one-cycle pulse at h=0, v=0
VGA_R  output  8  red
VGA_G  output  8  green
VGA_B  output  8  blue
VGA_HS  output  1  horizontal sync
VGA_VS  output  1  vertical sync
VGA_BLANK_N  output  1  high during visible pixels
VGA_SYNC_N  output  1  constant 0

Behaviour:
- Reset values: h=0, v=0; all outputs 0, except VGA_HS = VGA_VS = ~SYNC_POL. Active image = 0, line enable = 0.
- Counters:
  - h runs 0..H_TOTAL-1 and wraps; v increments on h wrap and runs 0..V_TOTAL-1.
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Sync timing:
  - HS active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - VS active likewise on v.
  - visible = (h < H_ACTIVE) && (v < V_ACTIVE).
- Window and fetch:
  - inwin = visible && h < IMG_W*SCALE && v < IMG_H*SCALE.
  - mem_rd_en = inwin && line enable.
  - mem_addr = base + (v/SCALE)*IMG_W + h/SCALE, computed with sub-pixel and row-base counters (no dividers or multipliers).
  - mem_addr is held when mem_rd_en = 0.
- Latency: HS, VS, BLANK_N, inwin and line enable pass through a MEM_LAT+1 stage delay. RGB is registered, so the pins lag the counter by exactly MEM_LAT+1 cycles, and all outputs stay aligned.
- Output colour: visible && inwin && enable → formatted mem_data; visible otherwise → BORDER; not visible → 0.
- image_sel is sampled only on the cycle frame_start is generated; a mid-frame change has no effect until the next frame.
- enable is sampled at h=0 of each line; a mid-line change takes effect on the next line.
- A pending frame_start coincides with the last line's wrap. rst mid-frame returns all counters and pipelines to reset values immediately (async); the first frame after release begins at h=0, v=0.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- When defined, add input test_mode (1 bit, sampled at frame_start). If set, mem_rd_en = 0 and the visible area shows 8 vertical colour bars, each H_ACTIVE/8 wide, in order white, yellow, cyan, green, magenta, red, blue, black (channel values 8'hFF/8'h00). Same MEM_LAT+1 alignment applies.
- When undefined, the port and logic are absent and behaviour is as above.

Test Plan:
- Defaults, release rst → line period 800 cycles, frame 420000 cycles; HS low at pins for counter h 656..751 (pins delayed 2 cycles); VS low lines 490..491; frame_start every 420000 cycles.
- IMG_W=4, IMG_H=4, SCALE=2 → mem_addr on lines 0 and 1: 0,0,1,1,2,2,3,3; line 2 starts at 4; h ≥ 8 and v ≥ 8 give BORDER at pins.
- MEM_LAT=3, PIX_FMT=0, memory returns data = addr[7:0] → pixel at counter (h=5, v=0) appears as R=G=B=8'h05 exactly 4 cycles later; BLANK_N aligned with it.
- Toggle image_sel 0→1 at v=100 → addresses stay in image 0 until frame end; the first read of the next frame is 65536.
- Drop enable at h=300, v=20 → line 20 keeps fetching; line 21 has mem_rd_en = 0 and black in the window; reassert → fetching resumes at the next line.
- Assert rst at h=400, v=200 → outputs go to reset values the same cycle; after release, VS first activates 490 lines later.
